vga_sync_generator: RTL and testbench
=====================================

// Module: vga_sync_generator
// PURPOSE
//   VGA raster timing source: the requesting end of the PIXEL_H/PIXEL_V -> PIXEL pixel-query interface.
//   Scans H/V counters, presents the current coordinate to the pixel source (game engine),
//   takes back the 3-bit RGB after the source's fixed registered latency, and drives the VGA pins.
//   HS/VS/DE are delay-matched to that latency, so colour and sync leave aligned on the same edge.
// PARAMETERS
//   H_VISIBLE     800  active pixels per line
//   H_FRONT        40  horizontal front porch, clocks
//   H_SYNC         48  horizontal sync width, clocks
//   H_BACK         40  horizontal back porch, clocks
//   V_VISIBLE     480  active lines per frame
//   V_FRONT        13  vertical front porch, lines
//   V_SYNC          3  vertical sync width, lines
//   V_BACK         29  vertical back porch, lines
//   HS_ACTIVE_HIGH  0  1: HS asserted high; 0: HS asserted low
//   VS_ACTIVE_HIGH  0  1: VS asserted high; 0: VS asserted low
//   PIXEL_LATENCY   1  clocks from PIXEL_H/PIXEL_V change to matching PIXEL (1..4)
// PORTS
//   VGA_CLOCK    in   1   pixel clock; the only clock
//   RESET_N      in   1   asynchronous, active-low reset
//   PIXEL        in   3   {R,G,B} from the pixel source, PIXEL_LATENCY clocks after the coordinate
//   PIXEL_H      out  11  current horizontal count, 0..H_TOTAL-1
//   PIXEL_V      out  11  current vertical count, 0..V_TOTAL-1
//   VGA_R        out  1   red pin
//   VGA_G        out  1   green pin
//   VGA_B        out  1   blue pin
//   VGA_HS       out  1   horizontal sync, polarity per HS_ACTIVE_HIGH
//   VGA_VS       out  1   vertical sync, polarity per VS_ACTIVE_HIGH
//   DISPLAY_EN   out  1   high while VGA_R/G/B carry an active-area pixel
//   FRAME_START  out  1   one-clock pulse when the pixel at (0,0) reaches the pins
// BEHAVIOUR
//   Totals: H_TOTAL = sum of the four H_* values (928); V_TOTAL = sum of the four V_* values (525).
//   Reset (RESET_N low, async):
//     h/v counters = 0; PIXEL_H/V = 0; RGB = 0; DISPLAY_EN = 0; FRAME_START = 0.
//     HS and VS are at their inactive level. All delay-line stages clear to the inactive/0 level.
//   Counters: h increments each clock; at H_TOTAL-1, h wraps to 0 and v increments.
//     v wraps to 0 at V_TOTAL-1 only on the h wrap.
//     PIXEL_H/PIXEL_V are driven directly from the counter registers.
//     They keep counting through blanking, so the source sees coordinates beyond 799/479.
//   Stage-0 decode (from the counters, same cycle):
//     de0 = (h < H_VISIBLE) && (v < V_VISIBLE)
//     hs0 = h in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1]
//     vs0 = v in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1]
//     fs0 = (h == 0) && (v == 0)
//   Delay line: de/hs/vs/fs pass through PIXEL_LATENCY register stages, then the output register.
//   Output register: VGA_RGB <= delayed_de ? PIXEL : 3'b000 (forced black in blanking).
//     HS and VS get their polarity applied at this register.
//   Latency: counter value to pins = PIXEL_LATENCY+1 clocks, identical for RGB, HS, VS, DE and FS.
//   Mid-frame reset release: raster restarts at (0,0) on the first clock after release.
//     The first FRAME_START appears PIXEL_LATENCY+1 clocks after release; no partial-frame sync glitch.
//   No PIXEL handshake: the source must honour PIXEL_LATENCY exactly.
// CONFIGURATION
//   VGA_TEST_PATTERN_EN defined:
//     PIXEL input is ignored; the active area shows 8 vertical colour bars.
//     Bar colour = (delayed h * 8 / H_VISIBLE) as {R,G,B}, i.e. bar 0 black through bar 7 white.
//     The h value is delay-matched like DE. Blanking stays black.
//   Macro undefined: PIXEL passes through as specified above. Timing and ports are identical either way.
// STRUCTURE
//   Package vga_timing_pkg holds:
//     default timing constants H_*/V_*; derived H_TOTAL/V_TOTAL; RGB width (3); colour constants.
//   One sub-module, vga_timing_counter: h/v counters plus stage-0 de/hs/vs/fs decode.
//   The top level holds the delay line, the output register and the test-pattern mux.
// TESTING
//   1 Reset: RESET_N=0 -> RGB=0, DE=0, FS=0, HS=VS=1 (active-low default), PIXEL_H=PIXEL_V=0.
//   2 Free run, two frames -> HS low 48 clocks every 928; VS low 3 lines every 525.
//     FRAME_START period = 487200 clocks.
//   3 Model source returning PIXEL = PIXEL_H[2:0] with latency 1 -> RGB at the pin = h mod 8
//     during active area, and DE rises exactly with h=0.
//   4 Source drives PIXEL=3'b111 constantly -> RGB=0 whenever DE=0 (h>=800 or v>=480).
//   5 RESET_N pulsed low at (h=400, v=200) -> all outputs return to reset levels asynchronously.
//     Counting restarts at (0,0); FS appears 2 clocks after release.
//   6 VGA_TEST_PATTERN_EN build -> active pixels at h=0/100/700 show 000/001/111; PIXEL ignored.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default VGA timing, derived totals, pixel/coordinate types and colour helpers
package vga_timing_pkg;
  localparam int H_VISIBLE = 800;
  localparam int H_FRONT = 40;
  localparam int H_SYNC = 48;
  localparam int H_BACK = 40;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT = 13;
  localparam int V_SYNC = 3;
  localparam int V_BACK = 29;
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int RGB_W = 3;
  localparam int COORD_W = 11;
  typedef logic [RGB_W-1:0] rgb_t;
  typedef logic [COORD_W-1:0] coord_t;
  localparam rgb_t BLACK = 3'b000;
  localparam rgb_t WHITE = 3'b111;
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic fs;
  } sync_t;
  function automatic rgb_t bar_color(input coord_t h, input int visible);
    return rgb_t'((int'(h) * 8) / visible);
  endfunction
endpackage

// File: rtl/vga_sync_generator_if.sv
// vga_sync_generator_if: pixel-query link; master presents the coordinate, slave returns the colour
interface vga_sync_generator_if;
  import vga_timing_pkg::*;
  coord_t PIXEL_H;
  coord_t PIXEL_V;
  rgb_t PIXEL;
  modport master(output PIXEL_H, output PIXEL_V, input PIXEL);
  modport slave(input PIXEL_H, input PIXEL_V, output PIXEL);
endinterface

// File: rtl/vga_timing_counter.sv
// vga_timing_counter: free-running h/v raster counters with same-cycle de/hs/vs/fs decode
module vga_timing_counter
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int H_FRONT = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC = vga_timing_pkg::H_SYNC,
  parameter int H_BACK = vga_timing_pkg::H_BACK,
  parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int V_FRONT = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC = vga_timing_pkg::V_SYNC,
  parameter int V_BACK = vga_timing_pkg::V_BACK
) (
  input  logic   clk,
  input  logic   rst_n,
  output coord_t h,
  output coord_t v,
  output sync_t  s0
);
  localparam int HT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int VT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_LO = H_VISIBLE + H_FRONT;
  localparam int VS_LO = V_VISIBLE + V_FRONT;
  logic h_last, v_last;
  assign h_last = h == coord_t'(HT - 1);
  assign v_last = v == coord_t'(VT - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      h <= '0;
      v <= '0;
    end else begin
      h <= h_last ? '0 : h + 1'b1;
      v <= !h_last ? v : v_last ? '0 : v + 1'b1;
    end
  always_comb begin
    s0.de = (h < coord_t'(H_VISIBLE)) && (v < coord_t'(V_VISIBLE));
    s0.hs = (h >= coord_t'(HS_LO)) && (h < coord_t'(HS_LO + H_SYNC));
    s0.vs = (v >= coord_t'(VS_LO)) && (v < coord_t'(VS_LO + V_SYNC));
    s0.fs = (h == '0) && (v == '0);
  end
endmodule

// File: rtl/vga_sync_generator.sv
// vga_sync_generator: VGA raster source; sync/DE delay-matched to the pixel source latency.
// Define VGA_TEST_PATTERN_EN to replace PIXEL with eight built-in vertical colour bars.
module vga_sync_generator
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int H_FRONT = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC = vga_timing_pkg::H_SYNC,
  parameter int H_BACK = vga_timing_pkg::H_BACK,
  parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int V_FRONT = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC = vga_timing_pkg::V_SYNC,
  parameter int V_BACK = vga_timing_pkg::V_BACK,
  parameter bit HS_ACTIVE_HIGH = 1'b0,
  parameter bit VS_ACTIVE_HIGH = 1'b0,
  parameter int PIXEL_LATENCY = 1
) (
  input  logic VGA_CLOCK,
  input  logic RESET_N,
  vga_sync_generator_if.master px,
  output logic VGA_R,
  output logic VGA_G,
  output logic VGA_B,
  output logic VGA_HS,
  output logic VGA_VS,
  output logic DISPLAY_EN,
  output logic FRAME_START
);
  coord_t h, v;
  sync_t s0, sd;
  sync_t dl [PIXEL_LATENCY];
  rgb_t src;
  vga_timing_counter #(
    .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
  ) u_counter (
    .clk(VGA_CLOCK),
    .rst_n(RESET_N),
    .h(h),
    .v(v),
    .s0(s0)
  );
  assign px.PIXEL_H = h;
  assign px.PIXEL_V = v;
  // decode travels alongside the source's pipeline so it meets the matching PIXEL
  always_ff @(posedge VGA_CLOCK or negedge RESET_N)
    if (!RESET_N) begin
      for (int i = 0; i < PIXEL_LATENCY; i++) dl[i] <= '0;
    end else begin
      dl[0] <= s0;
      for (int i = 1; i < PIXEL_LATENCY; i++) dl[i] <= dl[i-1];
    end
  assign sd = dl[PIXEL_LATENCY-1];
`ifdef VGA_TEST_PATTERN_EN
  coord_t hd [PIXEL_LATENCY];
  always_ff @(posedge VGA_CLOCK or negedge RESET_N)
    if (!RESET_N) begin
      for (int i = 0; i < PIXEL_LATENCY; i++) hd[i] <= '0;
    end else begin
      hd[0] <= h;
      for (int i = 1; i < PIXEL_LATENCY; i++) hd[i] <= hd[i-1];
    end
  assign src = bar_color(hd[PIXEL_LATENCY-1], H_VISIBLE);
`else
  assign src = px.PIXEL;
`endif
  always_ff @(posedge VGA_CLOCK or negedge RESET_N)
    if (!RESET_N) begin
      {VGA_R, VGA_G, VGA_B} <= BLACK;
      VGA_HS <= !HS_ACTIVE_HIGH;
      VGA_VS <= !VS_ACTIVE_HIGH;
      DISPLAY_EN <= 1'b0;
      FRAME_START <= 1'b0;
    end else begin
      {VGA_R, VGA_G, VGA_B} <= sd.de ? src : BLACK;
      VGA_HS <= sd.hs ^ !HS_ACTIVE_HIGH;
      VGA_VS <= sd.vs ^ !VS_ACTIVE_HIGH;
      DISPLAY_EN <= sd.de;
      FRAME_START <= sd.fs;
    end
endmodule

// File: tb/tb_vga_sync_generator.sv
// tb_vga_sync_generator: small-raster and default-raster instances checked against a position model
module tb_vga_sync_generator;
  import vga_timing_pkg::*;
  typedef struct {int hv, hf, hs, hb, vv, vf, vs, vb, lat;} cfg_t;
  typedef struct {int h, v, rgb; logic hs, vs, de, fs;} exp_t;
  typedef struct {int k, h, v, rgb, bar; logic hs, vs, de, fs;} vec_t;
  localparam int SL = 1;
  localparam int BL = 3;
`ifdef VGA_TEST_PATTERN_EN
  localparam bit PAT = 1'b1;
`else
  localparam bit PAT = 1'b0;
`endif
  cfg_t scfg = '{16, 2, 3, 3, 10, 2, 2, 2, SL};
  cfg_t bcfg = '{800, 40, 48, 40, 480, 13, 3, 29, BL};
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int k = 0;
  int mode = 1;
  logic [31:0] seed = 32'h0;
  int total = 0;
  int bad = 0;
  logic s_r, s_g, s_b, s_hs, s_vs, s_de, s_fs;
  logic b_r, b_g, b_b, b_hs, b_vs, b_de, b_fs;
  rgb_t spipe [SL];
  rgb_t bpipe [BL];
  always #5 clk = ~clk;
  vga_sync_generator_if sif();
  vga_sync_generator_if bif();
  vga_sync_generator #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(2), .PIXEL_LATENCY(SL)
  ) u_sm (
    .VGA_CLOCK(clk), .RESET_N(rst_n), .px(sif),
    .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b), .VGA_HS(s_hs), .VGA_VS(s_vs),
    .DISPLAY_EN(s_de), .FRAME_START(s_fs)
  );
  vga_sync_generator #(.PIXEL_LATENCY(BL)) u_bg (
    .VGA_CLOCK(clk), .RESET_N(rst_n), .px(bif),
    .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b), .VGA_HS(b_hs), .VGA_VS(b_vs),
    .DISPLAY_EN(b_de), .FRAME_START(b_fs)
  );
  function automatic rgb_t src_fn(input int m, input int h, input int v, input logic [31:0] sd);
    return m == 0 ? rgb_t'(h) : m == 1 ? rgb_t'(7) : rgb_t'(h * 5 + v * 3 + int'(sd));
  endfunction
  // registered pixel sources honouring each instance's latency exactly
  always @(posedge clk) begin
    spipe[0] <= src_fn(mode, int'(sif.PIXEL_H), int'(sif.PIXEL_V), seed);
    for (int i = 1; i < SL; i++) spipe[i] <= spipe[i-1];
    bpipe[0] <= src_fn(mode, int'(bif.PIXEL_H), int'(bif.PIXEL_V), seed);
    for (int i = 1; i < BL; i++) bpipe[i] <= bpipe[i-1];
  end
  assign sif.PIXEL = spipe[SL-1];
  assign bif.PIXEL = bpipe[BL-1];
  always @(posedge clk or negedge rst_n)
    if (!rst_n) k <= 0;
    else k <= k + 1;
  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s t=%0t k=%0d got=%0d want=%0d", nm, $time, k, act, want);
    end
  endtask
  // pins after kk clocks show the raster position kk-lat-1 clocks into the frame
  function automatic exp_t model(input int kk, input cfg_t c, input int m, input logic [31:0] sd);
    exp_t e;
    int ht, vt, p, h, v;
    ht = c.hv + c.hf + c.hs + c.hb;
    vt = c.vv + c.vf + c.vs + c.vb;
    e.h = kk % (ht * vt) % ht;
    e.v = kk % (ht * vt) / ht;
    e.rgb = 0; e.hs = 1'b1; e.vs = 1'b1; e.de = 1'b0; e.fs = 1'b0;
    if (kk > c.lat) begin
      p = (kk - c.lat - 1) % (ht * vt);
      h = p % ht;
      v = p / ht;
      e.de = h < c.hv && v < c.vv;
      e.hs = !(h >= c.hv + c.hf && h < c.hv + c.hf + c.hs);
      e.vs = !(v >= c.vv + c.vf && v < c.vv + c.vf + c.vs);
      e.fs = p == 0;
      if (e.de) e.rgb = PAT ? h * 8 / c.hv : int'(src_fn(m, h, v, sd));
    end
    return e;
  endfunction
  task automatic check_dut(input string tg, input cfg_t c, input coord_t h, input coord_t v,
                           input rgb_t rgb, input logic hs, input logic vs, input logic de, input logic fs);
    exp_t e;
    e = model(k, c, mode, seed);
    cmp({tg, ".h"}, 32'(h), e.h);
    cmp({tg, ".v"}, 32'(v), e.v);
    cmp({tg, ".rgb"}, 32'(rgb), e.rgb);
    cmp({tg, ".hs"}, 32'(hs), 32'(e.hs));
    cmp({tg, ".vs"}, 32'(vs), 32'(e.vs));
    cmp({tg, ".de"}, 32'(de), 32'(e.de));
    cmp({tg, ".fs"}, 32'(fs), 32'(e.fs));
  endtask
  always @(negedge clk) begin
    check_dut("sm", scfg, sif.PIXEL_H, sif.PIXEL_V, {s_r, s_g, s_b}, s_hs, s_vs, s_de, s_fs);
    check_dut("bg", bcfg, bif.PIXEL_H, bif.PIXEL_V, {b_r, b_g, b_b}, b_hs, b_vs, b_de, b_fs);
  end
  initial begin
    vec_t tab [13];
    logic found;
    int n;
    // small raster 24x16, latency 1, source constant white: pins show position k-2
    tab = '{
      '{1, 1, 0, 0, 0, 1, 1, 0, 0},
      '{2, 2, 0, 7, 0, 1, 1, 1, 1},
      '{3, 3, 0, 7, 0, 1, 1, 1, 0},
      '{17, 17, 0, 7, 7, 1, 1, 1, 0},
      '{18, 18, 0, 0, 0, 1, 1, 0, 0},
      '{20, 20, 0, 0, 0, 0, 1, 0, 0},
      '{22, 22, 0, 0, 0, 0, 1, 0, 0},
      '{23, 23, 0, 0, 0, 1, 1, 0, 0},
      '{26, 2, 1, 7, 0, 1, 1, 1, 0},
      '{242, 2, 10, 0, 0, 1, 1, 0, 0},
      '{290, 2, 12, 0, 0, 1, 0, 0, 0},
      '{338, 2, 14, 0, 0, 1, 1, 0, 0},
      '{386, 2, 0, 7, 0, 1, 1, 1, 1}
    };
    #1 rst_n = 1'b0;
    repeat (6) @(negedge clk);
    cmp("rst_bg_hs", 32'(b_hs), 1);
    cmp("rst_bg_vs", 32'(b_vs), 1);
    cmp("rst_bg_rgb", 32'({b_r, b_g, b_b}), 0);
    cmp("rst_bg_de", 32'(b_de), 0);
    cmp("rst_bg_fs", 32'(b_fs), 0);
    cmp("rst_bg_h", 32'(bif.PIXEL_H), 0);
    cmp("rst_bg_v", 32'(bif.PIXEL_V), 0);
    #1 rst_n = 1'b1;
    foreach (tab[i]) begin
      for (int g = 0; g < 1000 && k < tab[i].k; g++) @(negedge clk);
      cmp("tab_h", 32'(sif.PIXEL_H), tab[i].h);
      cmp("tab_v", 32'(sif.PIXEL_V), tab[i].v);
      cmp("tab_rgb", 32'({s_r, s_g, s_b}), PAT ? tab[i].bar : tab[i].rgb);
      cmp("tab_hs", 32'(s_hs), 32'(tab[i].hs));
      cmp("tab_vs", 32'(s_vs), 32'(tab[i].vs));
      cmp("tab_de", 32'(s_de), 32'(tab[i].de));
      cmp("tab_fs", 32'(s_fs), 32'(tab[i].fs));
    end
    for (int g = 0; g < 1000 && k < 800; g++) @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b1;
    found = 1'b0;
    for (int g = 0; g < 1000 && !found; g++) begin
      @(negedge clk);
      found = sif.PIXEL_H == 10 && sif.PIXEL_V == 5;
    end
    cmp("seek_10_5", 32'(found), 1);
    cmp("pre_rst_rgb", 32'({s_r, s_g, s_b}), PAT ? 4 : 7);
    #2 rst_n = 1'b0;
    #1;
    cmp("async_rgb", 32'({s_r, s_g, s_b}), 0);
    cmp("async_de", 32'(s_de), 0);
    cmp("async_fs", 32'(s_fs), 0);
    cmp("async_hs", 32'(s_hs), 1);
    cmp("async_vs", 32'(s_vs), 1);
    cmp("async_h", 32'(sif.PIXEL_H), 0);
    cmp("async_v", 32'(sif.PIXEL_V), 0);
    mode = 0;
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b1;
    n = 0;
    for (int g = 1; g <= 10 && n == 0; g++) begin
      @(negedge clk);
      if (s_fs) n = g;
    end
    cmp("fs_after_release", n, 2);
    repeat (3000) @(negedge clk);
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      #($urandom_range(1, 4)) rst_n = 1'b0;
      #1;
      mode = $urandom_range(0, 2);
      seed = $urandom;
      repeat (5) @(negedge clk);
      #1 rst_n = 1'b1;
      repeat ($urandom_range(300, 1500)) @(negedge clk);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
